mem_stage_lsu: RTL and testbench

//  Memory stage directly downstream of the execute stage. It holds the EX/MEM pipeline register
//  and runs loads/stores on a req/gnt/rvalid data-memory bus. It aligns store data, extracts and

---
 rtl/mem_stage_lsu.sv | 253 +++++++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// Memory stage: EX/MEM register, req/gnt/rvalid data-memory sequencer,
// store lane alignment and load extraction feeding the writeback register.
module mem_stage_lsu #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    input  logic [DATA_WIDTH-1:0] ex_opr_res,
    input  logic [DATA_WIDTH-1:0] ex_opr_b,
    input  logic [2:0]            ex_lsuop,
    input  logic                  ex_mem_rd,
    input  logic                  ex_mem_wr,
    input  logic [4:0]            ex_rd,
    input  logic                  ex_rf_en,
    output logic                  stall,
    output logic                  dm_req,
    output logic                  dm_we,
    output logic [ADDR_WIDTH-1:0] dm_addr,
    output logic [3:0]            dm_be,
    output logic [DATA_WIDTH-1:0] dm_wdata,
    input  logic                  dm_gnt,
    input  logic                  dm_rvalid,
    input  logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  wb_valid,
    output logic [4:0]            wb_rd,
    output logic                  wb_rf_en,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  wb_misaligned
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Access size; reserved lsuop codes behave as a word access.
    function automatic logic [1:0] size_of(input logic [2:0] op);
        logic [1:0] sz;
        case (op)
            3'b000, 3'b100: sz = SZ_B;
            3'b001, 3'b101: sz = SZ_H;
            default:        sz = SZ_W;
        endcase
        return sz;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] a);
        logic m;
        case (size_of(op))
            SZ_B:    m = 1'b0;
            SZ_H:    m = a[0];
            default: m = (a != 2'b00);
        endcase
        return m;
    endfunction

    function automatic logic [3:0] be_of(input logic [2:0] op, input logic [1:0] a);
        logic [3:0] be;
        case (size_of(op))
            SZ_B:    be = 4'b0001 << a;
            SZ_H:    be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] wdata_of(input logic [2:0] op, input logic [31:0] d);
        logic [31:0] w;
        case (size_of(op))
            SZ_B:    w = {4{d[7:0]}};
            SZ_H:    w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] op, input logic [1:0] a,
                                                 input logic [31:0] r);
        logic [7:0]  b;
        logic [15:0] h;
        logic        zext;
        logic [31:0] v;
        b    = r[8*a +: 8];
        h    = a[1] ? r[31:16] : r[15:0];
        zext = (op == 3'b100) || (op == 3'b101);
        case (size_of(op))
            SZ_B:    v = zext ? {24'd0, b} : {{24{b[7]}}, b};
            SZ_H:    v = zext ? {16'd0, h} : {{16{h[15]}}, h};
            default: v = r;
        endcase
        return v;
    endfunction

    logic [1:0]            state_r;
    logic [1:0]            state_next_s;
    logic                  stage_valid_r;
    logic                  mis_r;
    logic [2:0]            lsuop_r;
    logic [1:0]            addr_lo_r;
    logic [DATA_WIDTH-1:0] opr_res_r;
    logic [4:0]            rd_r;
    logic                  rf_en_r;
    logic [ADDR_WIDTH-1:0] dm_addr_r;
    logic [3:0]            dm_be_r;
    logic [DATA_WIDTH-1:0] dm_wdata_r;
    logic                  dm_we_r;

    logic                  wb_valid_r;
    logic [4:0]            wb_rd_r;
    logic                  wb_rf_en_r;
    logic [DATA_WIDTH-1:0] wb_data_r;
    logic                  wb_misaligned_r;

    logic                  stall_s;
    logic                  done_s;
    logic                  accept_s;
    logic                  ex_mem_s;
    logic                  ex_mis_s;
    logic                  go_req_s;
    logic [DATA_WIDTH-1:0] wb_data_s;

    // Decode of the incoming EX instruction.
    always_comb begin
        ex_mem_s = ex_mem_rd | ex_mem_wr;
        ex_mis_s = ex_mem_s & is_misaligned(ex_lsuop, ex_opr_res[1:0]);
        go_req_s = ex_valid & ex_mem_s & ~ex_mis_s;
    end

    // Stall and completion; stall falls in the completion cycle for back-to-back flow.
    always_comb begin
        stall_s = 1'b0;
        done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                stall_s = 1'b0;
                done_s  = stage_valid_r;
            end
            ST_REQ: begin
                stall_s = ~(dm_gnt & dm_we_r);
                done_s  = dm_gnt & dm_we_r;
            end
            ST_WAIT: begin
                stall_s = ~dm_rvalid;
                done_s  = dm_rvalid;
            end
            default: begin
                stall_s = 1'b0;
                done_s  = 1'b0;
            end
        endcase
        accept_s = ex_valid & ~stall_s;
    end

    // Next-state selection.
    always_comb begin
        state_next_s = state_r;
        if (!stall_s) begin
            state_next_s = go_req_s ? ST_REQ : ST_IDLE;
        end else if ((state_r == ST_REQ) && dm_gnt) begin
            state_next_s = ST_WAIT;
        end else begin
            state_next_s = state_r;
        end
    end

    // Writeback data: extracted load data only when finishing in WAIT.
    always_comb begin
        if (state_r == ST_WAIT) begin
            wb_data_s = load_extract(lsuop_r, addr_lo_r, dm_rdata);
        end else begin
            wb_data_s = opr_res_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // EX/MEM stage register with the bus fields precomputed at accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid_r <= 1'b0;
            mis_r         <= 1'b0;
            lsuop_r       <= 3'd0;
            addr_lo_r     <= 2'd0;
            opr_res_r     <= '0;
            rd_r          <= 5'd0;
            rf_en_r       <= 1'b0;
            dm_addr_r     <= '0;
            dm_be_r       <= 4'd0;
            dm_wdata_r    <= '0;
            dm_we_r       <= 1'b0;
        end else if (accept_s) begin
            stage_valid_r <= 1'b1;
            mis_r         <= ex_mis_s;
            lsuop_r       <= ex_lsuop;
            addr_lo_r     <= ex_opr_res[1:0];
            opr_res_r     <= ex_opr_res;
            rd_r          <= ex_rd;
            rf_en_r       <= ex_rf_en;
            dm_addr_r     <= {ex_opr_res[ADDR_WIDTH-1:2], 2'b00};
            dm_be_r       <= be_of(ex_lsuop, ex_opr_res[1:0]);
            dm_wdata_r    <= wdata_of(ex_lsuop, ex_opr_b);
            dm_we_r       <= ex_mem_wr;
        end else if (done_s) begin
            stage_valid_r <= 1'b0;
        end else begin
            stage_valid_r <= stage_valid_r;
        end
    end

    // Writeback register: one-cycle valid pulse, payload held between completions.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_r      <= 1'b0;
            wb_rd_r         <= 5'd0;
            wb_rf_en_r      <= 1'b0;
            wb_data_r       <= '0;
            wb_misaligned_r <= 1'b0;
        end else if (done_s) begin
            wb_valid_r      <= 1'b1;
            wb_rd_r         <= rd_r;
            wb_rf_en_r      <= rf_en_r & ~mis_r;
            wb_data_r       <= wb_data_s;
            wb_misaligned_r <= mis_r;
        end else begin
            wb_valid_r      <= 1'b0;
        end
    end

    assign stall         = stall_s;
    assign dm_req        = (state_r == ST_REQ);
    assign dm_we         = dm_we_r;
    assign dm_addr       = dm_addr_r;
    assign dm_be         = dm_be_r;
    assign dm_wdata      = dm_wdata_r;
    assign wb_valid      = wb_valid_r;
    assign wb_rd         = wb_rd_r;
    assign wb_rf_en      = wb_rf_en_r;
    assign wb_data       = wb_data_r;
    assign wb_misaligned = wb_misaligned_r;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: directed instructions push expected
// writebacks; a monitor pops and compares on every wb_valid pulse.
module tb_mem_stage_lsu;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_opr_res;
    logic [31:0] ex_opr_b;
    logic [2:0]  ex_lsuop;
    logic        ex_mem_rd;
    logic        ex_mem_wr;
    logic [4:0]  ex_rd;
    logic        ex_rf_en;
    logic        stall;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_rf_en;
    logic [31:0] wb_data;
    logic        wb_misaligned;

    typedef struct {
        logic [4:0]  rd;
        logic        rf_en;
        logic [31:0] data;
        logic        mis;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    int          gnt_delay = 0;
    int          req_cnt   = 0;
    logic        rv_pend   = 1'b0;
    logic        rv_en     = 1'b1;
    logic [31:0] mem_rdata = 32'd0;

    mem_stage_lsu dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_opr_res(ex_opr_res),
        .ex_opr_b(ex_opr_b), .ex_lsuop(ex_lsuop), .ex_mem_rd(ex_mem_rd),
        .ex_mem_wr(ex_mem_wr), .ex_rd(ex_rd), .ex_rf_en(ex_rf_en), .stall(stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_rf_en(wb_rf_en), .wb_data(wb_data),
        .wb_misaligned(wb_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Memory responder: grant after gnt_delay request cycles, rvalid the cycle after a read grant.
    always @(posedge clk) begin
        if (dm_req && dm_gnt) begin
            req_cnt <= 0;
            rv_pend <= !dm_we;
        end else begin
            if (dm_req) req_cnt <= req_cnt + 1;
            if (dm_rvalid) rv_pend <= 1'b0;
        end
    end

    always @(negedge clk) begin
        dm_gnt    = dm_req && (req_cnt >= gnt_delay);
        dm_rvalid = rv_pend && rv_en;
        dm_rdata  = mem_rdata;
    end

    // Monitor: every writeback pulse must match the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (wb_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wb: got rd=%0d data=0x%08h want no writeback", wb_rd, wb_data);
            end else begin
                e = sb_q.pop_front();
                chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                chk("wb_rf_en", {31'd0, wb_rf_en}, {31'd0, e.rf_en});
                chk("wb_data", wb_data, e.data);
                chk("wb_misaligned", {31'd0, wb_misaligned}, {31'd0, e.mis});
            end
        end
    end

    // Present one instruction and hold it until the DUT can take it.
    task automatic issue(input logic [31:0] res, input logic [31:0] b, input logic [2:0] op,
                         input logic mr, input logic mw, input logic [4:0] rd, input logic rf,
                         input logic push, input logic [31:0] exp_data, input logic exp_mis);
        int n;
        exp_t e;
        @(negedge clk);
        ex_valid = 1'b1; ex_opr_res = res; ex_opr_b = b; ex_lsuop = op;
        ex_mem_rd = mr; ex_mem_wr = mw; ex_rd = rd; ex_rf_en = rf;
        if (push) begin
            e.rd = rd; e.rf_en = rf & ~exp_mis; e.data = exp_data; e.mis = exp_mis;
            sb_q.push_back(e);
        end
        #2;
        n = 0;
        while (stall === 1'b1 && n < 50) begin
            @(negedge clk); #2; n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got stall=1 for %0d cycles want accept", n);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        ex_valid = 1'b0;
        #2;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(negedge clk); #2; n++;
        end
        chk("drain_empty", sb_q.size(), 32'd0);
    endtask

    initial begin
        rst = 1'b1; ex_valid = 1'b0; ex_opr_res = 32'd0; ex_opr_b = 32'd0; ex_lsuop = 3'd0;
        ex_mem_rd = 1'b0; ex_mem_wr = 1'b0; ex_rd = 5'd0; ex_rf_en = 1'b0;
        dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #2;
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_dm_req", {31'd0, dm_req}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);

        // Non-memory instruction
        issue(32'h0000_1234, 32'd0, 3'b010, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 32'h0000_1234, 1'b0);
        idle();
        chk("alu_stall", {31'd0, stall}, 32'd0);
        chk("alu_no_req", {31'd0, dm_req}, 32'd0);
        drain();

        // SB 0x1003
        issue(32'h0000_1003, 32'h0000_00A5, 3'b000, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 32'h0000_1003, 1'b0);
        idle();
        chk("sb_req", {31'd0, dm_req}, 32'd1);
        chk("sb_we", {31'd0, dm_we}, 32'd1);
        chk("sb_be", {28'd0, dm_be}, 32'h0000_0008);
        chk("sb_wdata", dm_wdata, 32'hA5A5_A5A5);
        chk("sb_addr", dm_addr, 32'h0000_1000);
        chk("sb_stall", {31'd0, stall}, 32'd0);
        drain();

        // SH 0x1002 with rf_en: writes back opr_res
        issue(32'h0000_1002, 32'h1234_BEEF, 3'b001, 1'b0, 1'b1, 5'd3, 1'b1, 1'b1, 32'h0000_1002, 1'b0);
        idle();
        chk("sh_be", {28'd0, dm_be}, 32'h0000_000C);
        chk("sh_wdata", dm_wdata, 32'hBEEF_BEEF);
        drain();

        // LH 0x2002 with grant delayed by three cycles
        gnt_delay = 3;
        mem_rdata = 32'h80FF_0000;
        issue(32'h0000_2002, 32'd0, 3'b001, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1, 32'hFFFF_80FF, 1'b0);
        idle();
        for (int i = 0; i < 4; i++) begin
            chk("lh_stall", {31'd0, stall}, 32'd1);
            chk("lh_req", {31'd0, dm_req}, 32'd1);
            chk("lh_addr", dm_addr, 32'h0000_2000);
            chk("lh_we", {31'd0, dm_we}, 32'd0);
            @(negedge clk); #2;
        end
        chk("lh_stall_release", {31'd0, stall}, 32'd0);
        gnt_delay = 0;
        drain();

        // LHU 0x2002
        issue(32'h0000_2002, 32'd0, 3'b101, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 32'h0000_80FF, 1'b0);
        idle();
        drain();

        // LB / LBU byte 1
        mem_rdata = 32'h0000_8000;
        issue(32'h0000_5001, 32'd0, 3'b000, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 32'hFFFF_FF80, 1'b0);
        issue(32'h0000_5001, 32'd0, 3'b100, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 32'h0000_0080, 1'b0);
        idle();
        drain();

        // Misaligned LW 0x2001
        issue(32'h0000_2001, 32'd0, 3'b010, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 32'h0000_2001, 1'b1);
        idle();
        chk("mis_no_req", {31'd0, dm_req}, 32'd0);
        chk("mis_stall", {31'd0, stall}, 32'd0);
        drain();

        // Back-to-back SW then LW
        mem_rdata = 32'h1234_5678;
        issue(32'h0000_3000, 32'hDEAD_BEEF, 3'b010, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 32'h0000_3000, 1'b0);
        issue(32'h0000_3004, 32'd0, 3'b010, 1'b1, 1'b0, 5'd10, 1'b1, 1'b1, 32'h1234_5678, 1'b0);
        chk("b2b_sw_req", {31'd0, dm_req}, 32'd1);
        chk("b2b_sw_we", {31'd0, dm_we}, 32'd1);
        chk("b2b_sw_wdata", dm_wdata, 32'hDEAD_BEEF);
        idle();
        chk("b2b_lw_req", {31'd0, dm_req}, 32'd1);
        chk("b2b_lw_we", {31'd0, dm_we}, 32'd0);
        chk("b2b_lw_addr", dm_addr, 32'h0000_3004);
        drain();

        // Reset while waiting for read data; the late rvalid must not write back
        rv_en = 1'b0;
        issue(32'h0000_4000, 32'd0, 3'b010, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0, 32'd0, 1'b0);
        idle();
        @(negedge clk); #2;
        chk("wait_stall", {31'd0, stall}, 32'd1);
        chk("wait_no_req", {31'd0, dm_req}, 32'd0);
        rst = 1'b1;
        @(negedge clk); #2;
        chk("rstw_req", {31'd0, dm_req}, 32'd0);
        chk("rstw_stall", {31'd0, stall}, 32'd0);
        chk("rstw_wb_valid", {31'd0, wb_valid}, 32'd0);
        rst = 1'b0;
        rv_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #2;
            chk("late_rvalid_no_wb", {31'd0, wb_valid}, 32'd0);
        end

        repeat (3) @(negedge clk);
        chk("final_queue_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
